counter_mod: RTL
================

Name: counter_mod

Overview:
- Parametrised successor to the team's fixed 16-bit enable counter.
- Features:
  - programmable modulo
  - up/down direction
  - parallel load
  - internal enable prescaler
  - registered terminal-count pulse
- Used as a timebase and event counter in the lab datapath designs, for example driving display refresh, the PWM period and the delay timers.

Parameters:
- BIT_SZ, 16, width of count, load_val and modulo.
- PRESCALE, 1, number of enabled cycles per count step; legal range is 1..2^16.
- RESET_VAL, 0, value count takes on asynchronous reset; must be <= modulo in use.

Ports:
- clock  input  1  rising-edge clock.
- areset_n  input  1  asynchronous active-low reset.
- enable  input  1  high = count-qualifying cycle; feeds the prescaler.
- sreset  input  1  synchronous clear, active high.
- up_down  input  1  1 = count up, 0 = count down; sampled on each step.
- load  input  1  synchronous parallel load, active high.
- load_val  input  BIT_SZ  value to load.
- modulo  input  BIT_SZ  terminal value; counting range is 0..modulo inclusive.
- count  output  BIT_SZ  registered count value.
- tc  output  1  registered terminal-count pulse, one clock wide.
- zero  output  1  combinational, equals (count == 0).

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-low.
- areset_n low:
  - count = RESET_VAL
  - prescaler = 0
  - tc = 0
  - Takes effect immediately, independent of clock.
  - Release is synchronous; the first step can occur no earlier than the first edge after release.
- Priority per rising edge: sreset > load > step > hold.
- sreset = 1:
  - count = 0, prescaler = 0, tc = 0.
  - load and enable are ignored that cycle.
- load = 1 (sreset = 0):
  - count = min(load_val, modulo).
  - prescaler = 0, tc = 0.
  - enable is ignored that cycle.
- Prescaler:
  - Internal counter of width clog2(PRESCALE), minimum 1 bit.
  - Increments only when enable = 1.
  - When it equals PRESCALE-1 and enable = 1, it returns to 0 and a step occurs that cycle.
  - With PRESCALE = 1, every enabled cycle is a step.
  - enable = 0: prescaler, count and tc all hold, except that tc is cleared.
- Step, up (up_down = 1):
  - If count >= modulo: count = 0, tc = 1.
  - Otherwise count = count + 1, tc = 0.
- Step, down (up_down = 0):
  - If count == 0: count = modulo, tc = 1.
  - Otherwise count = count - 1, tc = 0.
- tc timing and width:
  - tc rises on the same edge on which count takes its wrapped value.
  - tc is high for exactly one clock, then cleared on the next edge unless another wrap occurs.
- Boundary cases:
  - modulo = 0: count stays 0 and tc = 1 on every step.
  - modulo changed below the current count while counting up: the next step wraps to 0 with tc = 1.
  - Same case while counting down: decrement continues normally until 0.
  - Direction change takes effect at the next step; there is no extra latency.
  - Arithmetic is unsigned, width BIT_SZ; no carry or borrow escapes the block.
- Latency: one clock from a qualifying input to count/tc; zero follows count combinationally.

Optional Feature:
- Macro: COUNTER_SATURATE_EN.
- Defined:
  - Up-step at count >= modulo: count = modulo (held or clamped), tc = 1.
  - Down-step at count == 0: count holds 0, tc = 1.
  - tc then pulses on every further blocked step.
  - Load and sreset are unchanged.
- Undefined: the wrap-around behaviour above applies, and no saturation logic is synthesised.

Test Plan:
- Reset:
  - Stimulus: RESET_VAL = 5, areset_n low mid-cycle while enable = 1.
  - Response: count = 5 and tc = 0 immediately; no step on the first edge after release unless enable is high at that edge.
- Up wrap:
  - Stimulus: modulo = 9, up_down = 1, enable held high for 12 cycles from 0.
  - Response: count 1..9,0,1,2; tc high only in the cycle count = 0; zero high in the same cycle.
- Down wrap and direction change:
  - Stimulus: modulo = 3, load 1, up_down = 0, 3 enabled cycles, then up_down = 1 for 2 cycles.
  - Response: count 0,3(tc),2, then 3,0(tc).
- Priority and clamp:
  - Stimulus 1: sreset = 1 and load = 1 with load_val = 7 in the same cycle. Response: count = 0.
  - Stimulus 2: next cycle load = 1, load_val = 20, modulo = 15. Response: count = 15, tc = 0.
- Prescaler:
  - Stimulus: PRESCALE = 3, enable high for 9 cycles with enable dropped on cycle 4.
  - Response: count increments only on the 3rd, 6th and 9th enabled edges; prescaler holds while enable = 0.
- Saturate (COUNTER_SATURATE_EN):
  - Stimulus: modulo = 4, up from 3 for 4 steps.
  - Response: count 4,4,4,4; tc high on steps 2, 3 and 4.
  - Repeat with the macro undefined: count 4,0(tc),1,2.

Source files
------------

// File: rtl/counter_mod.sv
// counter_mod: parametrised modulo up/down counter with parallel load,
// enable prescaler and a registered one-clock terminal-count pulse.
//
// Optional feature macro: COUNTER_SATURATE_EN
//   defined   -> a blocked step (up at/above modulo, down at zero) clamps
//                instead of wrapping; tc still pulses on every such step.
//   undefined -> wrap-around counting; no saturation logic is built.
//
// Ports:
//   clock     rising-edge clock
//   areset_n  asynchronous active-low reset (count = RESET_VAL)
//   enable    count-qualifying cycle, feeds the prescaler
//   sreset    synchronous clear, highest priority
//   up_down   1 = up, 0 = down, sampled on each step
//   load      synchronous parallel load of min(load_val, modulo)
//   load_val  value to load
//   modulo    terminal value; range is 0..modulo inclusive
//   count     registered count
//   tc        registered terminal-count pulse, one clock wide
//   zero      combinational (count == 0)
module counter_mod #(
    parameter int unsigned BIT_SZ    = 16,
    parameter int unsigned PRESCALE  = 1,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic              clock,
    input  logic              areset_n,
    input  logic              enable,
    input  logic              sreset,
    input  logic              up_down,
    input  logic              load,
    input  logic [BIT_SZ-1:0] load_val,
    input  logic [BIT_SZ-1:0] modulo,
    output logic [BIT_SZ-1:0] count,
    output logic              tc,
    output logic              zero
);

    localparam int unsigned       PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [BIT_SZ-1:0] CNT_RST  = BIT_SZ'(RESET_VAL);

    logic [PRE_W-1:0]  pre_cnt;
    logic [PRE_W-1:0]  pre_nxt;
    logic [BIT_SZ-1:0] count_nxt;
    logic              tc_nxt;
    logic [BIT_SZ-1:0] load_clamped;
    logic              step;

    // Loads never place the count outside the 0..modulo range.
    assign load_clamped = (load_val > modulo) ? modulo : load_val;

    // Next-state: sreset > load > step > hold; tc defaults low so it is one clock wide.
    always_comb begin
        count_nxt = count;
        pre_nxt   = pre_cnt;
        tc_nxt    = 1'b0;
        step      = 1'b0;

        if (sreset) begin
            count_nxt = '0;
            pre_nxt   = '0;
        end else if (load) begin
            count_nxt = load_clamped;
            pre_nxt   = '0;
        end else if (enable) begin
            if (pre_cnt == PRE_LAST) begin
                pre_nxt = '0;
                step    = 1'b1;
            end else begin
                pre_nxt = pre_cnt + PRE_W'(1);
            end
        end

        if (step) begin
            if (up_down) begin
                // ">=" so a modulo lowered below the count ends the run at once.
                if (count >= modulo) begin
`ifdef COUNTER_SATURATE_EN
                    count_nxt = modulo;
`else
                    count_nxt = '0;
`endif
                    tc_nxt = 1'b1;
                end else begin
                    count_nxt = count + BIT_SZ'(1);
                end
            end else begin
                if (count == '0) begin
`ifdef COUNTER_SATURATE_EN
                    count_nxt = '0;
`else
                    count_nxt = modulo;
`endif
                    tc_nxt = 1'b1;
                end else begin
                    count_nxt = count - BIT_SZ'(1);
                end
            end
        end
    end

    // State registers.
    always_ff @(posedge clock or negedge areset_n) begin
        if (!areset_n) begin
            count   <= CNT_RST;
            pre_cnt <= '0;
            tc      <= 1'b0;
        end else begin
            count   <= count_nxt;
            pre_cnt <= pre_nxt;
            tc      <= tc_nxt;
        end
    end

    assign zero = (count == '0);

endmodule
